// File: rtl/img_byte_buffer.sv
// Byte-stream image assembler: packs 8 pixels per byte into a flat binary image
// and holds it for the inference controller until consumed or cleared.
module img_byte_buffer #(
  parameter int unsigned IMG_PIXELS     = 784,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic       clear_req,
  input  logic       result_ready,
  output logic       img_out [0:IMG_PIXELS-1],
  output logic       img_buffer_full,
  output logic [6:0] byte_count,
  output logic       overflow_err,
  output logic       timeout_err
);

  localparam int unsigned NUM_BYTES = IMG_PIXELS / 8;
  localparam int unsigned IDX_W     = $clog2(IMG_PIXELS);
  localparam int unsigned TO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [6:0]      LAST_BYTE = 7'(NUM_BYTES - 1);

  typedef enum logic {
    FILL,
    FULL
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              rr_q;
  logic              rr_rise;
  logic              accept;
  logic              consume;
  logic              idle_tick;
  logic              idle_expire;
  logic [TO_W-1:0]   idle_cnt;
  logic [IDX_W-1:0]  base;

  assign rr_rise = result_ready & ~rr_q;
  assign base    = IDX_W'(byte_count) << 3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    rx_ready        = 1'b0;
    img_buffer_full = 1'b0;
    accept          = 1'b0;
    consume         = 1'b0;
    case (state)
      FILL: begin
        rx_ready = 1'b1;
        accept   = rx_valid & ~clear_req;
        if (accept && byte_count == LAST_BYTE) state_nxt = FULL;
      end
      FULL: begin
        img_buffer_full = 1'b1;
        consume         = rr_rise | clear_req;
        if (consume) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // Idle timer only runs on a partially filled image with no accept or clear this cycle
  assign idle_tick   = (TIMEOUT_CYCLES != 0) && (state == FILL) && (byte_count != 7'd0)
                       && !accept && !clear_req;
  assign idle_expire = idle_tick && (idle_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q         <= 1'b0;
      byte_count   <= '0;
      idle_cnt     <= '0;
      overflow_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      rr_q        <= result_ready;
      timeout_err <= idle_expire;

      if (state == FULL) begin
        if (consume) byte_count <= '0;
      end else if (clear_req || idle_expire) begin
        byte_count <= '0;
      end else if (accept) begin
        byte_count <= byte_count + 7'd1;
      end

      if (idle_tick && !idle_expire) idle_cnt <= idle_cnt + TO_W'(1);
      else                           idle_cnt <= '0;

      if (clear_req)                      overflow_err <= 1'b0;
      else if (state == FULL && rx_valid) overflow_err <= 1'b1;
    end
  end

  // Byte MSB lands on the lowest pixel index of its 8-pixel slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_out <= '{default: 1'b0};
    end else if (accept) begin
      for (int unsigned i = 0; i < 8; i++) begin
        img_out[base + IDX_W'(i)] <= rx_byte[3'(7 - i)];
      end
    end
  end

endmodule

// File: tb/tb_img_byte_buffer.sv
// Directed self-checking bench for img_byte_buffer (timeout shortened to 20 cycles).
module tb_img_byte_buffer;

  localparam int unsigned IMG_PIXELS = 784;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ready;
  logic       clear_req;
  logic       result_ready;
  logic       img_out [0:IMG_PIXELS-1];
  logic       img_buffer_full;
  logic [6:0] byte_count;
  logic       overflow_err;
  logic       timeout_err;

  int n_cmp;
  int n_err;

  img_byte_buffer #(
    .IMG_PIXELS    (IMG_PIXELS),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_byte        (rx_byte),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .clear_req      (clear_req),
    .result_ready   (result_ready),
    .img_out        (img_out),
    .img_buffer_full(img_buffer_full),
    .byte_count     (byte_count),
    .overflow_err   (overflow_err),
    .timeout_err    (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] get_byte(input int unsigned k);
    logic [7:0] r;
    for (int unsigned i = 0; i < 8; i++) r[7-i] = img_out[8*k+i];
    return r;
  endfunction

  // Sends n bytes; with vary set, byte j of this burst is base ^ j
  task automatic send(input int n, input logic [7:0] base, input bit vary);
    for (int j = 0; j < n; j++) begin
      rx_valid = 1'b1;
      rx_byte  = vary ? (base ^ 8'(j)) : base;
      tick();
    end
    rx_valid = 1'b0;
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    rst_n        = 1'b0;
    rx_byte      = 8'h00;
    rx_valid     = 1'b0;
    clear_req    = 1'b0;
    result_ready = 1'b0;

    #3;
    check("rst_byte_count", 32'(byte_count), 0);
    check("rst_full", 32'(img_buffer_full), 0);
    check("rst_rx_ready", 32'(rx_ready), 1);
    check("rst_overflow", 32'(overflow_err), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    check("rst_pix0", 32'(img_out[0]), 0);
    #9 rst_n = 1'b1;
    tick();

    // Full image of 0xA5
    send(97, 8'hA5, 1'b0);
    check("a5_count97", 32'(byte_count), 97);
    check("a5_not_full97", 32'(img_buffer_full), 0);
    check("a5_ready97", 32'(rx_ready), 1);
    send(1, 8'hA5, 1'b0);
    check("a5_count98", 32'(byte_count), 98);
    check("a5_full", 32'(img_buffer_full), 1);
    check("a5_ready_low", 32'(rx_ready), 0);
    check("a5_byte0", 32'(get_byte(0)), 32'hA5);
    check("a5_pix0", 32'(img_out[0]), 1);
    check("a5_pix1", 32'(img_out[1]), 0);
    check("a5_pix783", 32'(img_out[783]), 1);

    // Overflow while full
    send(5, 8'hFF, 1'b0);
    check("ovf_set", 32'(overflow_err), 1);
    check("ovf_byte0", 32'(get_byte(0)), 32'hA5);
    check("ovf_byte97", 32'(get_byte(97)), 32'hA5);
    check("ovf_count", 32'(byte_count), 98);
    tick();
    tick();
    check("ovf_sticky", 32'(overflow_err), 1);
    check("ovf_still_full", 32'(img_buffer_full), 1);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("clr_ovf", 32'(overflow_err), 0);
    check("clr_full", 32'(img_buffer_full), 0);
    check("clr_ready", 32'(rx_ready), 1);
    check("clr_count", 32'(byte_count), 0);

    // result_ready edge consume, then hold high through the next fill
    send(98, 8'h3C, 1'b0);
    check("img2_full", 32'(img_buffer_full), 1);
    result_ready = 1'b1;
    tick();
    check("rr_consume_full", 32'(img_buffer_full), 0);
    check("rr_consume_count", 32'(byte_count), 0);
    check("rr_consume_ready", 32'(rx_ready), 1);
    for (int c = 0; c < 9; c++) tick();
    check("rr_hold_count", 32'(byte_count), 0);
    check("rr_hold_ready", 32'(rx_ready), 1);
    send(98, 8'h5A, 1'b1);
    check("img3_full", 32'(img_buffer_full), 1);
    tick();
    tick();
    check("img3_no_reconsume", 32'(img_buffer_full), 1);
    result_ready = 1'b0;
    tick();
    check("img3_fall_keep", 32'(img_buffer_full), 1);
    check("img3_byte0", 32'(get_byte(0)), 32'h5A);
    check("img3_byte50", 32'(get_byte(50)), 32'h68);
    check("img3_byte97", 32'(get_byte(97)), 32'h3B);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("img3_consume", 32'(img_buffer_full), 0);
    check("img3_consume_count", 32'(byte_count), 0);

    // Timeout after 20 idle cycles on a partial image
    send(50, 8'h11, 1'b0);
    check("to_count50", 32'(byte_count), 50);
    for (int c = 0; c < 19; c++) tick();
    check("to_pre_count", 32'(byte_count), 50);
    check("to_pre_pulse", 32'(timeout_err), 0);
    tick();
    check("to_pulse", 32'(timeout_err), 1);
    check("to_count0", 32'(byte_count), 0);
    tick();
    check("to_pulse_end", 32'(timeout_err), 0);
    send(98, 8'hC3, 1'b0);
    check("to_img_full", 32'(img_buffer_full), 1);
    check("to_img_byte0", 32'(get_byte(0)), 32'hC3);
    check("to_img_byte97", 32'(get_byte(97)), 32'hC3);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("to_img_cleared", 32'(img_buffer_full), 0);

    // Clear wins over a simultaneous byte
    send(30, 8'h77, 1'b0);
    check("cw_count30", 32'(byte_count), 30);
    clear_req = 1'b1;
    rx_valid  = 1'b1;
    rx_byte   = 8'hEE;
    tick();
    clear_req = 1'b0;
    rx_valid  = 1'b0;
    check("cw_count0", 32'(byte_count), 0);
    check("cw_byte30_unwritten", 32'(get_byte(30)), 32'hC3);
    send(1, 8'h96, 1'b0);
    check("cw_next_byte0", 32'(get_byte(0)), 32'h96);
    check("cw_count1", 32'(byte_count), 1);

    // Asynchronous reset mid-fill
    send(59, 8'h0F, 1'b0);
    check("ar_count60", 32'(byte_count), 60);
    #2 rst_n = 1'b0;
    #1;
    check("ar_count", 32'(byte_count), 0);
    check("ar_full", 32'(img_buffer_full), 0);
    check("ar_ready", 32'(rx_ready), 1);
    check("ar_byte0", 32'(get_byte(0)), 0);
    check("ar_byte59", 32'(get_byte(59)), 0);
    #2 rst_n = 1'b1;
    tick();
    send(98, 8'h81, 1'b1);
    check("ar_img_full", 32'(img_buffer_full), 1);
    check("ar_img_byte0", 32'(get_byte(0)), 32'h81);
    check("ar_img_byte97", 32'(get_byte(97)), 32'hE0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/img_byte_buffer.md
Name: img_byte_buffer

Overview:
- Upstream neighbour of the BNN inference controller.
- Assembles a 28x28 binary image from a byte stream (receiver side, valid/ready handshake), 8 pixels per byte.
- Presents the image as a flat pixel array and raises img_buffer_full.
- Holds the image stable until inference completes (rising edge of result_ready) or a clear is requested, then re-arms for the next image.

Parameters:
- IMG_PIXELS, 784, pixels per image; must be a multiple of 8. NUM_BYTES = IMG_PIXELS/8 = 98 (derived localparam).
- TIMEOUT_CYCLES, 1000000, idle cycles mid-image before a partial image is discarded; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- rx_byte  in  8  packed pixel byte.
- rx_valid  in  1  rx_byte valid.
- rx_ready  out  1  buffer can accept a byte.
- clear_req  in  1  one-cycle request: discard contents and re-arm.
- result_ready  in  1  from inference block; its rising edge means the image is consumed.
- img_out  out  1 x IMG_PIXELS (unpacked [0:IMG_PIXELS-1])  image pixels.
- img_buffer_full  out  1  complete image held.
- byte_count  out  7  bytes accepted for the current image, 0..NUM_BYTES.
- overflow_err  out  1  sticky: rx_valid seen while full.
- timeout_err  out  1  one-cycle pulse when a partial image is discarded.

Behaviour:
- Reset: asynchronous, active-low rst_n; clock clk.
- Reset values:
  - img_out all 0, byte_count 0, img_buffer_full 0, rx_ready 1.
  - overflow_err 0, timeout_err 0.
  - state FILL; result_ready edge-detect register 0.
- States: FILL, FULL.
- FILL:
  - rx_ready = 1.
  - A byte is accepted on a clock edge where rx_valid=1 and clear_req=0.
  - Mapping: accepted byte k (k = byte_count) writes img_out[8k+i] = rx_byte[7-i] for i=0..7 (MSB = lowest pixel index).
  - byte_count increments by 1.
  - When the accepted byte is byte NUM_BYTES-1: byte_count becomes NUM_BYTES, img_buffer_full=1 and rx_ready=0 from the next cycle; state goes to FULL.
- FULL:
  - rx_ready = 0; img_out frozen; no byte accepted.
  - rx_valid=1 in any FULL cycle sets overflow_err. The byte is dropped, not queued.
  - Exit to FILL on the edge where result_ready=1 and its previous sample was 0, or where clear_req=1.
  - On that edge: img_buffer_full<=0, byte_count<=0, rx_ready=1 from the next cycle.
  - img_out keeps its old contents until overwritten.
  - Constraint: img_buffer_full must be low before the inference controller returns to its idle state (3 cycles after it samples full). The edge-based exit meets this.
- result_ready held high: only the rising edge counts. A level that stays high never re-consumes.
- result_ready rising while in FILL: ignored.
- clear_req in FILL: byte_count<=0. If rx_valid=1 in the same cycle, the byte is discarded (clear wins).
- clear_req clears overflow_err in either state.
- Timeout: an idle counter runs in FILL when byte_count>0 and no byte is accepted; it resets on accept, clear, or entry to FILL.
  - On reaching TIMEOUT_CYCLES: byte_count<=0 and timeout_err pulses for 1 cycle.
  - Disabled when TIMEOUT_CYCLES=0. Not active in FULL.
- byte_count never exceeds NUM_BYTES and never wraps.
- Reset mid-fill or mid-FULL: immediate return to reset values; the partial image is lost.
- Throughput: 1 byte/cycle in FILL. Latency from last byte accept edge to img_buffer_full high is 0 extra cycles (visible in the following cycle).

Test Plan:
- Send 98 bytes of 0xA5 back-to-back -> img_out[0..7]=1,0,1,0,0,1,0,1; img_out[783]=1; byte_count=98; img_buffer_full=1 and rx_ready=0 in the cycle after the 98th accept.
- After full, pulse result_ready 0->1 and hold it high 10 cycles -> full drops after exactly one edge, byte_count=0, rx_ready=1; no second consume while result_ready stays high; a next 98-byte image fills correctly.
- In FULL, drive rx_valid=1 with 0xFF for 5 cycles -> no img_out change, overflow_err=1 and sticky; clear_req -> overflow_err=0, state FILL.
- TIMEOUT_CYCLES=20: send 50 bytes then idle 20 cycles -> timeout_err single-cycle pulse, byte_count=0; a fresh 98-byte image then completes normally.
- At byte_count=30, assert clear_req with rx_valid=1 in the same cycle -> byte_count=0, byte not written; next accepted byte lands at img_out[0..7].
- Deassert rst_n asynchronously at byte_count=60 -> all outputs return to reset values immediately; after release, a full image loads from pixel 0.
